mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_align.sv | 28 ++
 rtl/mem_stage.sv | 92 +++++++++
 tb/tb_mem_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared opcodes, access-size codes, FSM state type and alignment helper for the memory stage.
package mem_stage_pkg;
  localparam int BUS_64 = 64;
  localparam logic [4:0] OPCODE_LOAD  = 5'b00000;
  localparam logic [4:0] OPCODE_STORE = 5'b01000;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;
  typedef enum logic {S_IDLE, S_BUS} state_t;
  // Size lives in funct3[1:0] for both signed and unsigned variants.
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    return (f3[1:0] == 2'd1 & a[0]) | (f3[1:0] == 2'd2 & |a[1:0]) | (f3[1:0] == 2'd3 & |a);
  endfunction
endpackage

// File: rtl/mem_stage_align.sv
// mem_align: byte-lane extraction/extension for loads and store data shift/byte mask generation.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [2:0]        i_off,
  input  logic [BUS_64-1:0] i_wdata,
  input  logic [BUS_64-1:0] i_rdata,
  output logic [BUS_64-1:0] o_wdata,
  output logic [7:0]        o_wmask,
  output logic [BUS_64-1:0] o_rdata
);
  logic [BUS_64-1:0] w_lane;
  logic [7:0]        w_mask;
  always_comb begin
    w_lane  = i_rdata >> {i_off, 3'b000};
    w_mask  = i_funct3[1:0] == 2'd0 ? 8'h01 : i_funct3[1:0] == 2'd1 ? 8'h03 :
              i_funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    o_wdata = i_wdata << {i_off, 3'b000};
    o_wmask = w_mask << i_off;
    o_rdata = i_funct3 == F3_B  ? {{56{w_lane[7]}}, w_lane[7:0]} :
              i_funct3 == F3_H  ? {{48{w_lane[15]}}, w_lane[15:0]} :
              i_funct3 == F3_W  ? {{32{w_lane[31]}}, w_lane[31:0]} :
              i_funct3 == F3_BU ? {56'b0, w_lane[7:0]} :
              i_funct3 == F3_HU ? {48'b0, w_lane[15:0]} :
              i_funct3 == F3_WU ? {32'b0, w_lane[31:0]} : w_lane;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store unit between execute and writeback; one outstanding bus access, non-memory results pass through.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_opcode,
  input  logic [2:0]        ex_funct3,
  input  logic [BUS_64-1:0] ex_addr,
  input  logic [BUS_64-1:0] ex_wdata,
  input  logic              ex_rd_wen,
  input  logic [BUS_64-1:0] ex_rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BUS_64-1:0] mem_addr,
  output logic [BUS_64-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [BUS_64-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_rd_wen,
  output logic [BUS_64-1:0] wb_rd_data,
  output logic              misalign
);
  state_t            r_state, w_next;
  logic [BUS_64-1:0] r_addr, r_wdata, r_wb_rd_data;
  logic [2:0]        r_funct3;
  logic              r_store, r_wb_valid, r_wb_rd_wen, r_misalign;
  logic              w_acc, w_ld, w_st, w_mem, w_bad, w_go, w_done;
  logic [BUS_64-1:0] w_al_wdata, w_al_rdata;
  logic [7:0]        w_al_wmask;
  mem_align u_align (
    .i_funct3(r_funct3),
    .i_off   (r_addr[2:0]),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_wdata (w_al_wdata),
    .o_wmask (w_al_wmask),
    .o_rdata (w_al_rdata)
  );
  always_comb begin
    w_acc  = ex_valid & (r_state == S_IDLE);
    w_ld   = ex_opcode == OPCODE_LOAD;
    w_st   = ex_opcode == OPCODE_STORE;
    w_mem  = w_ld | w_st;
    w_bad  = misaligned(ex_funct3, ex_addr[2:0]) | (w_st & ex_funct3[2]) | (w_ld & ex_funct3 == 3'd7);
    w_go   = w_acc & w_mem & ~w_bad;
    w_done = (r_state == S_BUS) & mem_ack;
  end
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_next;
  always_comb
    w_next = r_state == S_IDLE ? (w_go ? S_BUS : S_IDLE) : (mem_ack ? S_IDLE : S_BUS);
  // Bus outputs come only from latched state, so they hold steady for the whole access.
  always_comb begin
    ex_ready  = r_state == S_IDLE;
    mem_req   = r_state == S_BUS;
    mem_we    = mem_req & r_store;
    mem_addr  = mem_req ? {r_addr[BUS_64-1:3], 3'b000} : '0;
    mem_wdata = mem_we ? w_al_wdata : '0;
    mem_wmask = mem_we ? w_al_wmask : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_store      <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd_wen  <= 1'b0;
      r_wb_rd_data <= '0;
      r_misalign   <= 1'b0;
    end else begin
      if (w_go) begin
        r_addr   <= ex_addr;
        r_wdata  <= ex_wdata;
        r_funct3 <= ex_funct3;
        r_store  <= w_st;
      end
      r_wb_valid   <= (w_acc & ~w_go) | w_done;
      r_wb_rd_wen  <= w_done ? ~r_store : (w_acc & ~w_mem & ex_rd_wen);
      r_wb_rd_data <= w_done ? w_al_rdata : ex_rd_data;
      r_misalign   <= w_acc & w_mem & w_bad;
    end
  end
  assign wb_valid   = r_wb_valid;
  assign wb_rd_wen  = r_wb_rd_wen;
  assign wb_rd_data = r_wb_rd_data;
  assign misalign   = r_misalign;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed load/store/ALU vectors; expected writebacks queued at issue, checked by an independent monitor.
module tb_mem_stage;
  localparam logic [4:0] LD = 5'b00000;
  localparam logic [4:0] ST = 5'b01000;
  localparam logic [4:0] OP = 5'b01100;
  logic        clk = 0, rst = 1, ex_valid = 0, ex_rd_wen = 0, mem_ack = 0;
  logic [4:0]  ex_opcode = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [63:0] ex_addr = '0, ex_wdata = '0, ex_rd_data = '0, mem_rdata = '0;
  logic        ex_ready, mem_req, mem_we, wb_valid, wb_rd_wen, misalign;
  logic [63:0] mem_addr, mem_wdata, wb_rd_data;
  logic [7:0]  mem_wmask;
  typedef struct {
    logic        wen;
    logic [63:0] data;
    logic        mis;
    int          cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_pass = 0, n_tot = 0;
  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd_wen(ex_rd_wen),
    .ex_rd_data(ex_rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd_wen(wb_rd_wen), .wb_rd_data(wb_rd_data), .misalign(misalign)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  task automatic expect_wb(input logic wen, input logic [63:0] d, input logic mis, input int dly);
    q.push_back('{wen, d, mis, cyc + dly});
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (wb_valid === 1'b1) begin
      if (q.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("wb_cycle", 64'(cyc), 64'(e.cyc));
        chk("wb_rd_wen", {63'b0, wb_rd_wen}, {63'b0, e.wen});
        chk("wb_misalign", {63'b0, misalign}, {63'b0, e.mis});
        if (e.wen) chk("wb_rd_data", wb_rd_data, e.data);
      end
    end else chk("wb_stray", {62'b0, wb_rd_wen, misalign}, 64'd0);
  end
  task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                       input logic wen, input logic [63:0] rd);
    ex_valid = 1; ex_opcode = op; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd_wen = wen; ex_rd_data = rd;
  endtask
  task automatic alu(input logic wen, input logic [63:0] d);
    @(negedge clk);
    drive(OP, 3'd0, 64'h0, 64'h0, wen, d);
    expect_wb(wen, d, 1'b0, 1);
  endtask
  task automatic bad_op(input logic [4:0] op, input logic [2:0] f3, input logic [63:0] a);
    @(negedge clk);
    drive(op, f3, a, 64'hFFFF, 1'b1, 64'h55);
    expect_wb(1'b0, 64'h0, 1'b1, 1);
    @(negedge clk);
    ex_valid = 0;
    chk("bad_no_req", {63'b0, mem_req}, 64'd0);
    chk("bad_ready", {63'b0, ex_ready}, 64'd1);
  endtask
  task automatic mem_op(input logic [4:0] op, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rdata, input int dly, input logic [63:0] e_addr,
                        input logic [63:0] e_wdata, input logic [7:0] e_mask, input logic [63:0] e_data);
    logic st;
    st = (op == ST);
    @(negedge clk);
    drive(op, f3, a, wd, 1'b1, 64'h77);
    chk("accept_ready", {63'b0, ex_ready}, 64'd1);
    @(negedge clk);
    ex_valid = 0;
    for (int i = 0; i <= dly; i++) begin
      chk("mem_req", {63'b0, mem_req}, 64'd1);
      chk("mem_we", {63'b0, mem_we}, {63'b0, st});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_wmask", {56'b0, mem_wmask}, {56'b0, e_mask});
      chk("ex_ready_bus", {63'b0, ex_ready}, 64'd0);
      if (i == dly) begin
        mem_ack = 1; mem_rdata = rdata;
        expect_wb(!st, e_data, 1'b0, 1);
      end
      @(negedge clk);
    end
    mem_ack = 0; mem_rdata = '0;
    chk("ready_after", {63'b0, ex_ready}, 64'd1);
    chk("req_after", {63'b0, mem_req}, 64'd0);
  endtask
  localparam logic [63:0] R = 64'h89ABCDEF_01234567;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'b0, ex_ready}, 64'd1);
    chk("rst_req_we", {62'b0, mem_req, mem_we}, 64'd0);
    chk("rst_wb", {61'b0, wb_valid, wb_rd_wen, misalign}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_wmask", {56'b0, mem_wmask}, 64'd0);
    chk("rst_wb_data", wb_rd_data, 64'd0);
    rst = 0;
    alu(1'b1, 64'd5);
    alu(1'b1, 64'd7);
    alu(1'b0, 64'd9);
    @(negedge clk) ex_valid = 0;
    mem_op(LD, 3'd0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 64'h1000, 64'h0, 8'h00, 64'hFFFFFFFF_FFFFFF80);
    mem_op(LD, 3'd2, 64'h1004, 64'h0, R, 2, 64'h1000, 64'h0, 8'h00, 64'hFFFFFFFF_89ABCDEF);
    mem_op(LD, 3'd5, 64'h100E, 64'h0, R, 0, 64'h1008, 64'h0, 8'h00, 64'h89AB);
    mem_op(LD, 3'd1, 64'h1002, 64'h0, R, 1, 64'h1000, 64'h0, 8'h00, 64'h0123);
    mem_op(LD, 3'd4, 64'h1001, 64'h0, R, 0, 64'h1000, 64'h0, 8'h00, 64'h45);
    mem_op(LD, 3'd3, 64'h1000, 64'h0, R, 5, 64'h1000, 64'h0, 8'h00, R);
    mem_op(LD, 3'd6, 64'h1004, 64'h0, R, 0, 64'h1000, 64'h0, 8'h00, 64'h00000000_89ABCDEF);
    mem_op(LD, 3'd0, 64'h1007, 64'h0, R, 0, 64'h1000, 64'h0, 8'h00, 64'hFFFFFFFF_FFFFFF89);
    mem_op(ST, 3'd1, 64'h2006, 64'hABCD, R, 1, 64'h2000, 64'hABCD0000_00000000, 8'hC0, 64'h0);
    mem_op(ST, 3'd0, 64'h2005, 64'h11223344_55667788, R, 0, 64'h2000, 64'h66778800_00000000, 8'h20, 64'h0);
    mem_op(ST, 3'd2, 64'h200C, 64'hDEADBEEF, R, 0, 64'h2008, 64'hDEADBEEF_00000000, 8'hF0, 64'h0);
    mem_op(ST, 3'd3, 64'h2010, 64'h01234567_89ABCDEF, R, 3, 64'h2010, 64'h01234567_89ABCDEF, 8'hFF, 64'h0);
    bad_op(LD, 3'd2, 64'h1002);
    bad_op(ST, 3'd1, 64'h2001);
    bad_op(ST, 3'd3, 64'h2004);
    bad_op(ST, 3'd4, 64'h2000);
    bad_op(LD, 3'd7, 64'h1000);
    @(negedge clk) mem_ack = 1;
    repeat (2) @(negedge clk);
    chk("idle_ack_req", {63'b0, mem_req}, 64'd0);
    chk("idle_ack_ready", {63'b0, ex_ready}, 64'd1);
    mem_ack = 0;
    @(negedge clk) drive(LD, 3'd3, 64'h3000, 64'h0, 1'b1, 64'h0);
    @(negedge clk) ex_valid = 0;
    chk("rstbus_req1", {63'b0, mem_req}, 64'd1);
    @(negedge clk) rst = 1;
    @(negedge clk) begin rst = 0; mem_ack = 1; mem_rdata = R; end
    chk("rstbus_req0", {63'b0, mem_req}, 64'd0);
    chk("rstbus_ready", {63'b0, ex_ready}, 64'd1);
    chk("rstbus_addr", mem_addr, 64'd0);
    @(negedge clk) mem_ack = 0;
    chk("rstbus_req_late", {63'b0, mem_req}, 64'd0);
    alu(1'b1, 64'hCAFE);
    @(negedge clk) ex_valid = 0;
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
